alu4b_ctrl: RTL and testbench



---
 rtl/alu4b_ctrl_if.sv | 34 +++
 rtl/alu4b_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu4b_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu4b_ctrl_if.sv
// rtl/alu4b_ctrl_if.sv - operand/result handshake bundle for alu4b_ctrl
// Purpose: groups the input (operand) and output (result) valid/ready channels.
// Signals:
//   in_valid/in_ready   operand pair + opcode handshake
//   op[1:0]             00 ADD, 01 SUB, 10 CMP, 11 ACC_ADD
//   a[0:3], b[0:3]      operands, bit 0 = MSB
//   out_valid/out_ready result handshake
//   out_r[0:3], out_c   result and carry/borrow
//   out_gt/lt/eq        compare flags of the operands actually used
// Modports: master = producer/consumer side, slave = alu4b_ctrl side.
interface alu4b_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [0:3] a;
  logic [0:3] b;
  logic       out_valid;
  logic       out_ready;
  logic [0:3] out_r;
  logic       out_c;
  logic       out_gt;
  logic       out_lt;
  logic       out_eq;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out_r, out_c, out_gt, out_lt, out_eq
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out_r, out_c, out_gt, out_lt, out_eq
  );
endinterface

// File: rtl/alu4b_ctrl.sv
// rtl/alu4b_ctrl.sv - registered operation sequencer around a 4-bit ALU
// Purpose: accepts one operand pair + opcode per in_valid/in_ready transfer,
//   runs it through alu4b, and holds the registered result in a one-entry
//   output buffer until out_ready.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu4b_ctrl_if.slave (operand and result handshakes)
// Optional feature: define ALU4B_CTRL_ACC_EN to build the accumulator that
//   ACC_ADD uses as operand A; otherwise ACC_ADD behaves as ADD.

// Combinational 4-bit ALU, bit 0 = MSB.
// amab: a > b, ameb: a < b, aib: a == b.
module alu4b (
  input  logic [0:3] a,
  input  logic [0:3] b,
  output logic [0:3] sum,
  output logic       c_sum,
  output logic [0:3] res,
  output logic       c_res,
  output logic       amab,
  output logic       ameb,
  output logic       aib
);
  assign {c_sum, sum} = {1'b0, a} + {1'b0, b};
  // Five-bit difference: bit 4 is set exactly when a < b (borrow).
  assign {c_res, res} = {1'b0, a} - {1'b0, b};
  assign amab = (a > b);
  assign ameb = (a < b);
  assign aib  = (a == b);
endmodule

module alu4b_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  alu4b_ctrl_if.slave bus
);
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic       accept;
  logic [0:3] a_eff;
  logic [0:3] sum, res;
  logic       c_sum, c_res, amab, ameb, aib;
  logic [0:3] r_d, r_q;
  logic       c_d, c_q, gt_q, lt_q, eq_q;

  // The buffer may take a new op when empty or when its entry leaves this cycle.
  assign bus.in_ready = (state_q == S_EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef ALU4B_CTRL_ACC_EN
  localparam logic [1:0] OP_ACC = 2'b11;
  logic [0:3] acc_q;

  assign a_eff = (bus.op == OP_ACC) ? acc_q : bus.a;

  // CMP produces no arithmetic result, so it must not disturb the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 4'b0000;
    end else if (accept && (bus.op != OP_CMP)) begin
      acc_q <= r_d;
    end
  end
`else
  assign a_eff = bus.a;
`endif

  alu4b u_alu (
    .a     (a_eff),
    .b     (bus.b),
    .sum   (sum),
    .c_sum (c_sum),
    .res   (res),
    .c_res (c_res),
    .amab  (amab),
    .ameb  (ameb),
    .aib   (aib)
  );

  always_comb begin
    r_d = sum;
    c_d = c_sum;
    case (bus.op)
      OP_SUB: begin
        r_d = res;
        c_d = c_res;
      end
      OP_CMP: begin
        r_d = 4'b0000;
        c_d = 1'b0;
      end
      default: begin
        r_d = sum;   // ADD and ACC_ADD
        c_d = c_sum;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (!accept && bus.out_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result registers only move on accept, so a stalled entry stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= 4'b0000;
      c_q  <= 1'b0;
      gt_q <= 1'b0;
      lt_q <= 1'b0;
      eq_q <= 1'b0;
    end else if (accept) begin
      r_q  <= r_d;
      c_q  <= c_d;
      gt_q <= amab;
      lt_q <= ameb;
      eq_q <= aib;
    end
  end

  assign bus.out_valid = (state_q == S_FULL);
  assign bus.out_r     = r_q;
  assign bus.out_c     = c_q;
  assign bus.out_gt    = gt_q;
  assign bus.out_lt    = lt_q;
  assign bus.out_eq    = eq_q;
endmodule

// File: tb/tb_alu4b_ctrl.sv
// tb/tb_alu4b_ctrl.sv - self-checking bench for alu4b_ctrl
module tb_alu4b_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

`ifdef ALU4B_CTRL_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  alu4b_ctrl_if bus ();

  alu4b_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: buffer occupancy, expected result, accumulator.
  bit         m_full;
  logic [0:3] m_r;
  logic       m_c, m_gt, m_lt, m_eq;
  logic [0:3] m_acc;
  logic       obs_in_ready, exp_in_ready;
  logic [8:0] obs, expv;

  task automatic model_reset();
    m_full = 0; m_r = 4'b0000; m_c = 0; m_gt = 0; m_lt = 0; m_eq = 0;
    m_acc = 4'b0000;
  endtask

  // Arithmetic meaning of each opcode on plain integers.
  task automatic model_op(input logic [1:0] o, input logic [0:3] aa, input logic [0:3] bb,
                          output logic [0:3] r, output logic c,
                          output logic gt, output logic lt, output logic eq);
    int ea, eb, s;
    ea = (ACC_EN && o == 2'b11) ? int'(m_acc) : int'(aa);
    eb = int'(bb);
    case (o)
      2'b01: begin s = ea - eb + 16; r = 4'(s % 16); c = (ea < eb); end
      2'b10: begin r = 4'b0000; c = 1'b0; end
      default: begin s = ea + eb; r = 4'(s % 16); c = (s > 15); end
    endcase
    gt = (ea > eb); lt = (ea < eb); eq = (ea == eb);
  endtask

  // Drives one cycle at the falling edge and advances the model at the rising edge.
  task automatic drive_cycle(input logic v, input logic [1:0] o, input logic [0:3] aa,
                             input logic [0:3] bb, input logic rdy);
    logic acc_now;
    logic [0:3] r;
    logic c, gt, lt, eq;
    @(negedge clk);
    bus.in_valid = v; bus.op = o; bus.a = aa; bus.b = bb; bus.out_ready = rdy;
    #1;
    obs_in_ready = bus.in_ready;
    exp_in_ready = !m_full || rdy;
    acc_now = v && exp_in_ready;
    model_op(o, aa, bb, r, c, gt, lt, eq);
    @(posedge clk);
    if (acc_now) begin
      m_full = 1; m_r = r; m_c = c; m_gt = gt; m_lt = lt; m_eq = eq;
      if (ACC_EN && o != 2'b10) m_acc = r;
    end else if (rdy) begin
      m_full = 0;
    end
    #1;
    obs  = {bus.out_valid, bus.out_r, bus.out_c, bus.out_gt, bus.out_lt, bus.out_eq};
    expv = {m_full, m_r, m_c, m_gt, m_lt, m_eq};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 0; bus.op = 2'b00; bus.a = 4'b0000; bus.b = 4'b0000; bus.out_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.out_r, bus.out_c, bus.out_gt, bus.out_lt, bus.out_eq} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {bus.out_valid, bus.out_r, bus.out_c, bus.out_gt, bus.out_lt, bus.out_eq}, 9'b0);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    // ADD 0111+0101
    drive_cycle(1, 2'b00, 4'b0111, 4'b0101, 1);
    checks++;
    if (obs !== {1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL add_7_5 got=%b exp=%b", obs, {1'b1, 4'b1100, 4'b0100});
    end
    // ADD 1111+0001 wraps with carry
    drive_cycle(1, 2'b00, 4'b1111, 4'b0001, 1);
    checks++;
    if (obs !== {1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL add_wrap got=%b exp=%b", obs, {1'b1, 4'b0000, 4'b1100});
    end
    // SUB 0011-0101 borrows
    drive_cycle(1, 2'b01, 4'b0011, 4'b0101, 1);
    checks++;
    if (obs !== {1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sub_borrow got=%b exp=%b", obs, {1'b1, 4'b1110, 4'b1010});
    end
    // CMP equal
    drive_cycle(1, 2'b10, 4'b1010, 4'b1010, 1);
    checks++;
    if (obs !== {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL cmp_eq got=%b exp=%b", obs, {1'b1, 4'b0000, 4'b0001});
    end
    // Drain: nothing offered, result leaves
    drive_cycle(0, 2'b00, 4'b0000, 4'b0000, 1);
    checks++;
    if (obs[8] !== 1'b0) begin
      failures++; $display("FAIL drain_valid got=%b exp=0", obs[8]);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] held;
    drive_cycle(1, 2'b00, 4'b0001, 4'b0010, 0);
    held = obs;
    checks++;
    if (obs !== {1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL bp_first got=%b exp=%b", obs, {1'b1, 4'b0011, 4'b0010});
    end
    drive_cycle(1, 2'b00, 4'b0100, 4'b0100, 0);
    checks++;
    if (obs_in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_in_ready got=%b exp=0", obs_in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 2'($urandom), 4'($urandom), 4'($urandom), 0);
      checks++;
      if (obs !== held) begin
        failures++; $display("FAIL bp_hold cycle=%0d got=%b exp=%b", i, obs, held);
      end
    end
    drive_cycle(1, 2'b00, 4'b0100, 4'b0100, 1);
    checks++;
    if (obs_in_ready !== 1'b1 || obs !== {1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL bp_second in_ready=%b got=%b exp=1 %b", obs_in_ready, obs,
               {1'b1, 4'b1000, 4'b0001});
    end
    drive_cycle(0, 2'b00, 4'b0000, 4'b0000, 1);
    checks++;
    if (obs[8] !== 1'b0) begin
      failures++; $display("FAIL bp_drain got=%b exp=0", obs[8]);
    end
  endtask

  task automatic test_acc_chain();
    logic [0:3] e1, e2, e3;
    logic       c3;
    if (ACC_EN) begin e1 = 4'b0101; e2 = 4'b1001; e3 = 4'b0101; c3 = 1'b1; end
    else        begin e1 = 4'b0101; e2 = 4'b0111; e3 = 4'b1111; c3 = 1'b0; end
    drive_cycle(1, 2'b00, 4'b0011, 4'b0010, 1);
    checks++;
    if (obs[7:4] !== e1) begin
      failures++; $display("FAIL acc_step1 got=%b exp=%b", obs[7:4], e1);
    end
    drive_cycle(1, 2'b11, 4'b0011, 4'b0100, 1);
    checks++;
    if (obs[7:4] !== e2) begin
      failures++; $display("FAIL acc_step2 got=%b exp=%b", obs[7:4], e2);
    end
    drive_cycle(1, 2'b11, 4'b0011, 4'b1100, 1);
    checks++;
    if (obs[7:3] !== {e3, c3}) begin
      failures++; $display("FAIL acc_step3 got=%b exp=%b", obs[7:3], {e3, c3});
    end
    checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL acc_model got=%b exp=%b", obs, expv);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 2'b01, 4'b1001, 4'b0010, 0);
    checks++;
    if (obs[8] !== 1'b1) begin
      failures++; $display("FAIL ar_full got=%b exp=1", obs[8]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_r, bus.out_c, bus.out_gt, bus.out_lt, bus.out_eq} !== 9'b0
        || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got=%b in_ready=%b exp=000000000 1",
               {bus.out_valid, bus.out_r, bus.out_c, bus.out_gt, bus.out_lt, bus.out_eq},
               bus.in_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // Accumulator must read back as zero after reset.
    drive_cycle(1, 2'b11, 4'b0001, 4'b0110, 1);
    checks++;
    if (obs[7:4] !== (ACC_EN ? 4'b0110 : 4'b0111)) begin
      failures++;
      $display("FAIL ar_acc_zero got=%b exp=%b", obs[7:4], (ACC_EN ? 4'b0110 : 4'b0111));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(3, 0) != 0), 2'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom_range(3, 0) != 0));
      checks++;
      if (obs_in_ready !== exp_in_ready) begin
        failures++;
        $display("FAIL rand_in_ready i=%0d got=%b exp=%b", i, obs_in_ready, exp_in_ready);
      end
      if (m_full) begin
        checks++;
        if (obs !== expv) begin
          failures++; $display("FAIL rand_result i=%0d got=%b exp=%b", i, obs, expv);
        end
        checks++;
        if (!$onehot(obs[2:0])) begin
          failures++; $display("FAIL rand_onehot i=%0d got=%b exp=onehot", i, obs[2:0]);
        end
      end else begin
        checks++;
        if (obs[8] !== 1'b0) begin
          failures++; $display("FAIL rand_empty i=%0d got=%b exp=0", i, obs[8]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_acc_chain();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
endmodule
